sccb_slave_unit: RTL and testbench

SCCB/I2C-compatible responder: the camera-side end of the two-wire bus driven by the SCCB master. It decodes start/stop, matches a 7-bit device ID, and services 3-phase writes and 2-phase-write + 2-phase-read sequences against an internal 8-bit register file. It serves as the bench model for master verification and as an on-FPGA emulated sensor, and exposes a write-strobe port to fabric logic.

---
 rtl/sccb_pkg.sv | 23 ++
 rtl/sccb_slave_unit_if.sv | 26 ++
 rtl/sccb_regfile.sv | 26 ++
 rtl/sccb_slave_unit.sv | 206 ++++++++++++++++++++
 tb/tb_sccb_slave_unit.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: the responder FSM states and the bus bit conventions.
package sccb_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StId,
    StIdAck,
    StSub,
    StSubAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdAck,
    StIgnore
  } sccb_state_e;

  localparam logic AckBit = 1'b0;
  localparam logic NaBit  = 1'b1;

  // Position of the R/W flag within the 8-bit ID byte.
  localparam int unsigned RwBitIdx = 0;

endpackage

// File: rtl/sccb_slave_unit_if.sv
// Bus clock and fabric-side write strobe of the SCCB responder.
interface sccb_slave_unit_if;

  logic       sio_c;
  logic       reg_we;
  logic [7:0] reg_waddr;
  logic [7:0] reg_wdata;
  logic       busy;

  modport slave (
    input  sio_c,
    output reg_we,
    output reg_waddr,
    output reg_wdata,
    output busy
  );

  modport master (
    output sio_c,
    input  reg_we,
    input  reg_waddr,
    input  reg_wdata,
    input  busy
  );

endinterface

// File: rtl/sccb_regfile.sv
// Register file of the emulated sensor: one synchronous write port, asynchronous read.
module sccb_regfile #(
  parameter int unsigned REG_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [REG_AW-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [2**REG_AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**REG_AW; i++) mem_q[i] <= 8'h00;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sccb_slave_unit.sv
// SCCB/I2C responder: start/stop decode, device-ID match, 3-phase writes and
// 2-phase-write + 2-phase-read sequences against an internal register file.
module sccb_slave_unit
  import sccb_pkg::*;
#(
  parameter logic [6:0]  DEV_ID      = 7'h21,
  parameter int unsigned REG_AW      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  inout  wire                 sio_d,
  sccb_slave_unit_if.slave    bus
);

  localparam logic [REG_AW-1:0] PtrOne = {{(REG_AW-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  sccb_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic [7:0]        shift_next;
  logic [REG_AW-1:0] ptr_q, ptr_d;
  logic              rnw_q, rnw_d;
  logic              drive_low_q, drive_low_d;
  logic              busy_q, busy_d;
  logic              reg_we_q, reg_we_d;
  logic [7:0]        waddr_q, waddr_d, wdata_q, wdata_d;
  logic [7:0]        rf_rdata;
  logic [2:0]        bit_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.sio_c};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sio_d};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  // SIO_C must be high in both samples, so an SIO_C edge always wins over START/STOP.
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  assign shift_next = {shift_q, sda_s};
  assign bit_idx    = 3'(4'd7 - cnt_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rnw_d       = rnw_q;
    drive_low_d = drive_low_q;
    busy_d      = busy_q;
    reg_we_d    = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;

    if (start_det) begin
      state_d     = StId;
      cnt_d       = 4'd0;
      drive_low_d = 1'b0;
    end else if (stop_det) begin
      state_d     = StIdle;
      cnt_d       = 4'd0;
      drive_low_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      unique case (state_q)
        StId, StSub, StWdata: begin
          if (scl_rise) begin
            shift_d = shift_next[6:0];
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              if (state_q == StId) begin
                if (shift_next[7:1] == DEV_ID) begin
                  state_d = StIdAck;
                  busy_d  = 1'b1;
                  rnw_d   = shift_next[RwBitIdx];
                end else begin
                  state_d = StIgnore;
                  busy_d  = 1'b0;
                end
              end else if (state_q == StSub) begin
                ptr_d   = shift_next[REG_AW-1:0];
                state_d = StSubAck;
              end else begin
                reg_we_d = 1'b1;
                waddr_d  = 8'(ptr_q);
                wdata_d  = shift_next;
                ptr_d    = ptr_q + PtrOne;
                state_d  = StWdataAck;
              end
            end
          end
        end
        // cnt_q marks whether the master's 9th rising edge has been seen.
        StIdAck, StSubAck, StWdataAck: begin
          if (scl_rise) begin
            cnt_d = 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              drive_low_d = 1'b1;
            end else begin
              drive_low_d = 1'b0;
              cnt_d       = 4'd0;
              if (state_q != StIdAck) begin
                state_d = StWdata;
              end else if (rnw_q) begin
                state_d     = StRdata;
                drive_low_d = ~rf_rdata[7];
              end else begin
                state_d = StSub;
              end
            end
          end
        end
        StRdata: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              drive_low_d = 1'b0;
              cnt_d       = 4'd0;
              state_d     = StRdAck;
            end else begin
              drive_low_d = ~rf_rdata[bit_idx];
            end
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            if (sda_s == AckBit) begin
              ptr_d   = ptr_q + PtrOne;
              cnt_d   = 4'd0;
              state_d = StRdata;
            end else begin
              state_d = StIgnore;
            end
          end
        end
        default: drive_low_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      shift_q     <= 7'd0;
      ptr_q       <= '0;
      rnw_q       <= 1'b0;
      drive_low_q <= 1'b0;
      busy_q      <= 1'b0;
      reg_we_q    <= 1'b0;
      waddr_q     <= 8'd0;
      wdata_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rnw_q       <= rnw_d;
      drive_low_q <= drive_low_d;
      busy_q      <= busy_d;
      reg_we_q    <= reg_we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  sccb_regfile #(
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (reg_we_d),
    .waddr_i (ptr_q),
    .wdata_i (shift_next),
    .raddr_i (ptr_q),
    .rdata_o (rf_rdata)
  );

  // Open-drain: only ever pull low or release.
  assign sio_d         = drive_low_q ? 1'b0 : 1'bz;
  assign bus.reg_we    = reg_we_q;
  assign bus.reg_waddr = waddr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sccb_slave_unit.sv
// Self-checking bench: bit-banged SCCB master plus a register-file/pointer reference model.
module tb_sccb_slave_unit;

  localparam int H = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic m_low;
  wire  sio_d;

  always #5 clk = ~clk;

  assign sio_d = m_low ? 1'b0 : 1'bz;
  pullup (sio_d);

  sccb_slave_unit_if bus ();

  sccb_slave_unit #(
    .DEV_ID      (7'h21),
    .REG_AW      (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sio_d (sio_d),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int dut_low_cnt = 0;

  logic [15:0] mon_q [$];
  logic [15:0] exp_q [$];
  logic [7:0]  model_mem [256];
  logic [7:0]  model_ptr;

  always @(negedge clk) begin
    if (bus.reg_we) mon_q.push_back({bus.reg_waddr, bus.reg_wdata});
    if (sio_d === 1'b0 && !m_low) dut_low_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic start_cond();
    m_low = 1'b0;
    wait_clk(H / 2);
    bus.sio_c = 1'b1;
    wait_clk(H);
    m_low = 1'b1;
    wait_clk(H);
    bus.sio_c = 1'b0;
    wait_clk(H / 2);
  endtask

  task automatic stop_cond();
    m_low = 1'b1;
    wait_clk(H / 2);
    bus.sio_c = 1'b1;
    wait_clk(H);
    m_low = 1'b0;
    wait_clk(H);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    m_low = ~b;
    wait_clk(H / 2);
    bus.sio_c = 1'b1;
    wait_clk(H / 2);
    s = sio_d;
    wait_clk(H / 2);
    bus.sio_c = 1'b0;
    wait_clk(H / 2);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic recv_byte(input logic ack_bit, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(1'b1, d[i]);
    bit_xfer(ack_bit, s);
  endtask

  task automatic compare_we(input string tag);
    check({tag, "_count"}, mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) check(tag, mon_q[i], exp_q[i]);
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic do_write(input logic [7:0] sub, input logic [7:0] data [4], input int n);
    logic a;
    start_cond();
    send_byte(8'h42, a);
    check("wr_id_ack", a, 1'b0);
    check("wr_busy", bus.busy, 1'b1);
    send_byte(sub, a);
    check("wr_sub_ack", a, 1'b0);
    model_ptr = sub;
    for (int i = 0; i < n; i++) begin
      send_byte(data[i], a);
      check("wr_data_ack", a, 1'b0);
      exp_q.push_back({model_ptr, data[i]});
      model_mem[model_ptr] = data[i];
      model_ptr = model_ptr + 8'd1;
    end
    stop_cond();
    check("wr_busy_after_stop", bus.busy, 1'b0);
    compare_we("wr_we");
  endtask

  task automatic do_read(input logic [7:0] sub, input int n);
    logic a;
    logic [7:0] d;
    logic [7:0] idx;
    start_cond();
    send_byte(8'h42, a);
    send_byte(sub, a);
    check("rd_sub_ack", a, 1'b0);
    start_cond();
    send_byte(8'h43, a);
    check("rd_id_ack", a, 1'b0);
    for (int i = 0; i < n; i++) begin
      recv_byte((i == n - 1) ? 1'b1 : 1'b0, d);
      idx = sub + 8'(i);
      check("rd_data", d, model_mem[idx]);
    end
    stop_cond();
    check("rd_busy_after_stop", bus.busy, 1'b0);
    compare_we("rd_no_we");
  endtask

  initial begin
    logic a, s;
    logic [7:0] data [4];
    logic [7:0] sub;
    int n;

    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    model_ptr = 8'h00;
    m_low     = 1'b0;
    bus.sio_c = 1'b1;
    rst_n     = 1'b0;
    wait_clk(5);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_we", bus.reg_we, 1'b0);
    check("rst_waddr", bus.reg_waddr, 8'h00);
    check("rst_wdata", bus.reg_wdata, 8'h00);
    check("rst_sio_d", sio_d, 1'b1);
    rst_n = 1'b1;
    wait_clk(5);

    // 3-phase write
    data = '{8'h80, 8'h00, 8'h00, 8'h00};
    do_write(8'h12, data, 1);

    // Read-back
    data = '{8'h3A, 8'h00, 8'h00, 8'h00};
    do_write(8'h0C, data, 1);
    do_read(8'h0C, 1);

    // Sequential with pointer wrap
    data = '{8'h11, 8'h22, 8'h00, 8'h00};
    do_write(8'hFF, data, 2);
    do_read(8'hFF, 2);

    // Foreign ID
    dut_low_cnt = 0;
    start_cond();
    send_byte(8'h60, a);
    check("foreign_nack", a, 1'b1);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'($urandom), a);
      check("foreign_busy", bus.busy, 1'b0);
    end
    stop_cond();
    check("foreign_no_drive", dut_low_cnt, 0);
    compare_we("foreign_we");

    // START after 4 data bits discards the partial byte
    start_cond();
    send_byte(8'h42, a);
    send_byte(8'h05, a);
    bit_xfer(1'b1, s);
    bit_xfer(1'b0, s);
    bit_xfer(1'b1, s);
    bit_xfer(1'b0, s);
    compare_we("partial_we");
    data = '{8'h99, 8'h00, 8'h00, 8'h00};
    do_write(8'h05, data, 1);

    // Randomized bursts checked against the model
    for (int k = 0; k < 3; k++) begin
      sub = 8'($urandom);
      n   = int'($urandom_range(1, 4));
      for (int i = 0; i < 4; i++) data[i] = 8'($urandom);
      do_write(sub, data, n);
      do_read(sub, n);
    end

    // Reset while the slave drives the ID ACK
    start_cond();
    for (int i = 7; i >= 0; i--) bit_xfer(((8'h42 >> i) & 8'h01) != 0, s);
    m_low = 1'b0;
    wait_clk(1);
    check("ack_driven", sio_d, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_release_sio_d", sio_d, 1'b1);
    check("rst_busy_mid", bus.busy, 1'b0);
    wait_clk(3);
    bus.sio_c = 1'b1;
    wait_clk(H);
    rst_n = 1'b1;
    wait_clk(H);
    mon_q.delete();
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    do_read(8'h12, 1);
    data = '{8'($urandom), 8'h00, 8'h00, 8'h00};
    do_write(8'h40, data, 1);
    do_read(8'h40, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
